// File: rtl/lzss_decoder_if.sv
// Token/byte stream bundle for lzss_decoder: token input, decoded byte output, status.
// The decoder uses the slave modport; the token source and byte sink use master.
interface lzss_decoder_if #(
  parameter int WORD_SIZE = 8
);
  logic                 tok_valid;
  logic [WORD_SIZE:0]   tok_i;
  logic                 tok_ready;
  logic [WORD_SIZE-1:0] data_o;
  logic                 o_valid;
  logic                 out_ready;
  logic                 busy;
  logic                 err;

  modport master (
    output tok_valid, tok_i, out_ready,
    input  tok_ready, data_o, o_valid, busy, err
  );

  modport slave (
    input  tok_valid, tok_i, out_ready,
    output tok_ready, data_o, o_valid, busy, err
  );
endinterface

// File: rtl/lzss_decoder.sv
// LZSS token decoder: literals and (offset, length) back-references into a shift-register history.
// Define LZSS_DECODER_ERR_CHECK_EN to reject zero-length and out-of-fill references with an err pulse.
module lzss_decoder #(
  parameter int WORD_SIZE   = 8,
  parameter int WINDOW_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  lzss_decoder_if.slave     bus
);
  localparam int OFF_BITS = $clog2(WINDOW_SIZE);
  localparam int LEN_BITS = WORD_SIZE - OFF_BITS;
  localparam int CNT_BITS = OFF_BITS + 1;

  typedef enum logic {IDLE, COPY} state_t;

  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] hist [WINDOW_SIZE];
  logic [WORD_SIZE-1:0] data_q;
  logic                 o_valid_q;
  logic [OFF_BITS-1:0]  off_q;
  logic [LEN_BITS-1:0]  remaining;
  logic [CNT_BITS-1:0]  hist_cnt;

  logic                 is_ref;
  logic [OFF_BITS-1:0]  tok_off;
  logic [LEN_BITS-1:0]  tok_len;
  logic                 load_ok;
  logic                 tok_fire;
  logic                 ref_bad;
  logic                 start_copy;
  logic                 lit_load;
  logic                 copy_load;
  logic                 load;
  logic [WORD_SIZE-1:0] load_byte;

  assign is_ref  = bus.tok_i[WORD_SIZE];
  assign tok_off = bus.tok_i[WORD_SIZE-1:LEN_BITS];
  assign tok_len = bus.tok_i[LEN_BITS-1:0];

  // The output register may load whenever it is empty or being drained this cycle.
  assign load_ok    = !o_valid_q || bus.out_ready;
  assign tok_fire   = bus.tok_valid && bus.tok_ready;
  assign start_copy = tok_fire && is_ref && !ref_bad;
  assign lit_load   = tok_fire && !is_ref;
  assign copy_load  = (state == COPY) && load_ok;
  assign load       = lit_load || copy_load;
  assign load_byte  = lit_load ? bus.tok_i[WORD_SIZE-1:0] : hist[off_q];

`ifdef LZSS_DECODER_ERR_CHECK_EN
  logic err_q;

  assign ref_bad = (tok_len == '0) || ({1'b0, tok_off} >= hist_cnt);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= tok_fire && is_ref && ref_bad;
  end

  assign bus.err = err_q;
`else
  // Zero-length references are silently dropped; out-of-fill offsets read reset-zero history.
  assign ref_bad = (tok_len == '0);
  assign bus.err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: each comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_copy)                           state_nxt = COPY;
      COPY: if (copy_load && remaining == LEN_BITS'(1)) state_nxt = IDLE;
      default:                                        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.tok_ready = 1'b0;
    bus.busy      = 1'b0;
    unique case (state)
      IDLE:    bus.tok_ready = load_ok;
      COPY:    bus.busy      = 1'b1;
      default: ;
    endcase
  end

  // NOTE: the history is explicitly cleared on reset because out-of-fill references must read zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      o_valid_q <= 1'b0;
      off_q     <= '0;
      remaining <= '0;
      hist_cnt  <= '0;
      for (int i = 0; i < WINDOW_SIZE; i++) hist[i] <= '0;
    end else begin
      if (load) begin
        data_q    <= load_byte;
        o_valid_q <= 1'b1;
        hist[0]   <= load_byte;
        for (int i = 1; i < WINDOW_SIZE; i++) hist[i] <= hist[i-1];
        if (hist_cnt != CNT_BITS'(WINDOW_SIZE)) hist_cnt <= hist_cnt + CNT_BITS'(1);
      end else if (bus.out_ready) begin
        o_valid_q <= 1'b0;
      end

      // Offset stays fixed for the whole copy so overlapping copies repeat with period offset+1.
      if (start_copy) begin
        off_q     <= tok_off;
        remaining <= tok_len;
      end else if (copy_load) begin
        remaining <= remaining - LEN_BITS'(1);
      end
    end
  end

  assign bus.data_o  = data_q;
  assign bus.o_valid = o_valid_q;
endmodule

// File: tb/tb_lzss_decoder.sv
// Directed self-checking bench for lzss_decoder; expectations are hand-computed per token sequence.
// Outputs are sampled 1 ns after the rising edge; transfers are logged on the falling edge.
module tb_lzss_decoder;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [7:0] xfer_q [$];

  lzss_decoder_if #(.WORD_SIZE(8)) bus ();

  lzss_decoder #(.WORD_SIZE(8), .WINDOW_SIZE(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.out_ready) xfer_q.push_back(bus.data_o);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [8:0] t);
    bus.tok_valid = 1'b1;
    bus.tok_i     = t;
    cyc();
    bus.tok_valid = 1'b0;
  endtask

  initial begin
    logic done;
    logic all_5a;
    rst           = 1'b1;
    bus.tok_valid = 1'b0;
    bus.tok_i     = '0;
    bus.out_ready = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    check("rst_o_valid",   16'(bus.o_valid),   16'h0);
    check("rst_data",      16'(bus.data_o),    16'h0);
    check("rst_busy",      16'(bus.busy),      16'h0);
    check("rst_err",       16'(bus.err),       16'h0);
    check("rst_tok_ready", 16'(bus.tok_ready), 16'h1);

    // Three back-to-back literals.
    put(9'h041); check("lit_a", {7'h0, bus.o_valid, bus.data_o}, 16'h141);
    put(9'h042); check("lit_b", {7'h0, bus.o_valid, bus.data_o}, 16'h142);
    put(9'h043); check("lit_c", {7'h0, bus.o_valid, bus.data_o}, 16'h143);
    cyc();       check("lit_drain", 16'(bus.o_valid), 16'h0);

    // Offset 2, length 3 replays A, B, C.
    put(9'h113);
    check("ref_busy0",  {14'h0, bus.busy, bus.tok_ready}, 16'h2);
    check("ref_nodata", 16'(bus.o_valid), 16'h0);
    cyc(); check("ref_b1", {6'h0, bus.busy, bus.o_valid, bus.data_o}, 16'h341);
    check("ref_tokrdy_low", 16'(bus.tok_ready), 16'h0);
    cyc(); check("ref_b2", {6'h0, bus.busy, bus.o_valid, bus.data_o}, 16'h342);
    cyc(); check("ref_b3", {6'h0, bus.busy, bus.o_valid, bus.data_o}, 16'h143);
    check("ref_idle_rdy", 16'(bus.tok_ready), 16'h1);
    cyc();

    // Overlapping copy: offset 0, length 7 after one 0x5A.
    xfer_q.delete();
    put(9'h05A); check("run_lit", {7'h0, bus.o_valid, bus.data_o}, 16'h15A);
    put(9'h107); check("run_start", {14'h0, bus.busy, bus.o_valid}, 16'h2);
    for (int i = 0; i < 7; i++) begin
      cyc();
      check($sformatf("run_b%0d", i), {7'h0, bus.o_valid, bus.data_o}, 16'h15A);
    end
    check("run_busy_end", 16'(bus.busy), 16'h0);
    cyc();
    check("run_drain", 16'(bus.o_valid), 16'h0);
    check("run_count", 16'(xfer_q.size()), 16'd8);

    // Same copy with a 3-cycle consumer stall after the first byte.
    xfer_q.delete();
    put(9'h107);
    cyc(); check("stall_first", {7'h0, bus.o_valid, bus.data_o}, 16'h15A);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("stall_hold%0d", i), {6'h0, bus.busy, bus.o_valid, bus.data_o}, 16'h35A);
    end
    bus.out_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      cyc();
      if (!bus.busy && !bus.o_valid) done = 1'b1;
    end
    check("stall_finish", 16'(done), 16'h1);
    check("stall_count", 16'(xfer_q.size()), 16'd7);
    all_5a = 1'b1;
    foreach (xfer_q[i]) if (xfer_q[i] != 8'h5A) all_5a = 1'b0;
    check("stall_bytes", 16'(all_5a), 16'h1);

    // Reset while the third copied byte is on the output.
    put(9'h107);
    repeat (3) cyc();
    check("abort_pre", {6'h0, bus.busy, bus.o_valid, bus.data_o}, 16'h35A);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("abort_state", {13'h0, bus.o_valid, bus.busy, bus.tok_ready}, 16'h1);
    check("abort_data", 16'(bus.data_o), 16'h0);
    put(9'h011); check("abort_lit", {7'h0, bus.o_valid, bus.data_o}, 16'h111);

    // In-fill reference (offset 1, length 1) after 0x11, 0x22.
    put(9'h022); check("fill_lit", {7'h0, bus.o_valid, bus.data_o}, 16'h122);
    put(9'h109); check("fill_busy", 16'(bus.busy), 16'h1);
    cyc();       check("fill_ref", {6'h0, bus.busy, bus.o_valid, bus.data_o}, 16'h111);

    // Offset 5 with only three bytes emitted.
    put(9'h129);
`ifdef LZSS_DECODER_ERR_CHECK_EN
    check("oof_err", {13'h0, bus.err, bus.busy, bus.o_valid}, 16'h4);
    cyc();
    check("oof_err_clr", {13'h0, bus.err, bus.busy, bus.o_valid}, 16'h0);
`else
    check("oof_busy", {13'h0, bus.err, bus.busy, bus.o_valid}, 16'h2);
    cyc();
    check("oof_zero", {5'h0, bus.err, bus.busy, bus.o_valid, bus.data_o}, 16'h100);
`endif
    cyc();

    // Zero-length reference is consumed without output.
    put(9'h100);
`ifdef LZSS_DECODER_ERR_CHECK_EN
    check("len0_err", {13'h0, bus.err, bus.busy, bus.o_valid}, 16'h4);
`else
    check("len0_err", {13'h0, bus.err, bus.busy, bus.o_valid}, 16'h0);
`endif
    cyc();
    check("len0_idle", {13'h0, bus.err, bus.o_valid, bus.tok_ready}, 16'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
